pipe_stage_hs: RTL
==================

# pipe_stage_hs

Parametrised pipeline stage register for the WISC-16 processor pipeline, replacing the hand-sized per-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) with one block. Carries a free-form data payload plus a control-signal vector and uses a valid/ready handshake for stalls. Supports flush, which inserts a bubble. Control bits of a non-valid entry are forced to zero, so a bubble never writes the register file or memory.

## Interface
- `DATA_W`, default 64: payload width (PC, operands, immediate, register IDs); never cleared by flush.
- `CTRL_W`, default 8: control vector width (reg write enable, memory enable/write enable, halt, ...); zeroed for bubbles.
- `clk` input 1: clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `flush` input 1: discard all held entries and any input accepted in the same cycle.
- `in_valid` input 1: upstream presents an entry.
- `in_ready` output 1: stage can accept; a transfer occurs when `in_valid && in_ready`.
- `in_data` input DATA_W: upstream payload.
- `in_ctrl` input CTRL_W: upstream control vector.
- `out_valid` output 1: the head entry is valid.
- `out_ready` input 1: downstream consumes the head; a transfer occurs when `out_valid && out_ready`.
- `out_data` output DATA_W: head payload.
- `out_ctrl` output CTRL_W: head control vector; equals 0 whenever `out_valid`=0.
- `occupancy` output 2: number of valid entries held (0..2).

## Operation
- Entries: the main entry drives the outputs. The skid entry exists only when PIPE_SKID_EN is defined.
- States:
  - EMPTY (occupancy 0)
  - BUSY (main valid, occupancy 1)
  - FULL (main and skid valid, occupancy 2; skid builds only).
- EMPTY:
  - `in_valid` → BUSY, main ← input.
- BUSY:
  - `in_valid && out_ready` → BUSY, main ← input.
  - `in_valid && !out_ready` → FULL, skid ← input (skid builds). Without skid, `in_ready`=0 here, so no accept.
  - `!in_valid && out_ready` → EMPTY.
  - `!in_valid && !out_ready` → hold.
- FULL:
  - `out_ready` → BUSY, main ← skid.
  - otherwise hold.
  - No accept in FULL.
- Flush has top priority. From any state → EMPTY; `out_valid`=0 and `out_ctrl`=0 from the next cycle. An input accepted in the flush cycle is dropped. A downstream consumption in the flush cycle still completes.
- `out_data` holds its last loaded value when not valid. Its content is don't-care but stable; it does not toggle on flush.
- Payload and control are stored unmodified; no arithmetic on them.
- `occupancy` = number of valid entries; it never exceeds 1 without skid.

## Timing
- Reset (asynchronous, immediate on `rst`=1):
  - state EMPTY; `out_valid`=0, `out_ctrl`=0, `out_data`=0, `occupancy`=0.
  - `in_ready`=1 once `rst` deasserts.
- Latency: an accepted input appears on `out_*` on the next rising edge (1 cycle), in both configurations.
- With skid, `in_ready` is a registered function of state: `in_ready = (state != FULL)`. It has no combinational path from `out_ready`.
- Without skid, `in_ready = !out_valid || out_ready` (combinational). This gives full throughput, one entry per cycle, when `out_ready`=1.
- Reset asserted mid-transfer clears everything; no partial entry survives.
- Order is preserved: main always holds the older entry, skid the newer.

## Configuration
- Macro `PIPE_SKID_EN`.
- Defined: 2-entry skid buffer, FULL state reachable, registered `in_ready`. Use this to break long stall-ready timing paths.
- Undefined: single entry, states EMPTY/BUSY only, combinational `in_ready`, `occupancy` ≤ 1. Skid storage is not synthesised.

## Structure
- Package `pipe_pkg` holds:
  - state typedef `pipe_state_t` {EMPTY, BUSY, FULL};
  - constant `PIPE_OCC_W`=2;
  - default widths `PIPE_DATA_W_DEF`=64 and `PIPE_CTRL_W_DEF`=8.
- Sub-module `pipe_entry`: one storage slot (data, ctrl, valid) with `load` and `clear` inputs; `clear` zeroes only valid and ctrl. It is instantiated once for main and once for skid, the latter under `PIPE_SKID_EN`.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle with data held → `out_valid`=0, `out_ctrl`=0, `out_data`=0, `occupancy`=0 immediately, without waiting for a clock edge.
- Streaming: `in_data`=0x0001..0x0010 on consecutive cycles with `out_ready`=1 → same sequence on `out_data` one cycle later, no gaps, `in_ready` constantly 1.
- Stall (skid on): push 0xAAAA, then 0xBBBB with `out_ready`=0 → occupancy 2, `in_ready`=0, `out_data`=0xAAAA. Release `out_ready` → 0xAAAA then 0xBBBB, occupancy 1 then 0.
- Stall (skid off): `out_ready`=0 with one entry held → `in_ready`=0, a 0xBBBB offer is not accepted, `out_data` stays 0xAAAA.
- Flush: in FULL with `in_ctrl`=0xFF, assert `flush` while `in_valid`=1 → next cycle `out_valid`=0, `out_ctrl`=0x00, occupancy 0, flushed input never appears.
- Bubble control: `in_valid`=0 for 3 cycles with `in_ctrl`=0xFF → `out_ctrl` stays 0x00 throughout.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline stage register.
package pipe_pkg;

  localparam int unsigned PIPE_OCC_W      = 2;
  localparam int unsigned PIPE_DATA_W_DEF = 64;
  localparam int unsigned PIPE_CTRL_W_DEF = 8;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } pipe_state_t;

  // Number of valid entries held in a given state.
  function automatic logic [PIPE_OCC_W-1:0] occ_of_state(input pipe_state_t s);
    logic [PIPE_OCC_W-1:0] occ;
    occ = '0;
    case (s)
      BUSY:    occ = 2'd1;
      FULL:    occ = 2'd2;
      default: occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/pipe_entry.sv
// One storage slot of the stage: payload, control vector and valid flag.
// clear drops the entry (valid and ctrl to zero) but leaves the payload alone,
// so out_data stays stable after a flush or drain.
module pipe_entry
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = PIPE_DATA_W_DEF,
  parameter int unsigned CTRL_W = PIPE_CTRL_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic [DATA_W-1:0] d_data,
  input  logic [CTRL_W-1:0] d_ctrl,
  output logic              q_valid,
  output logic [DATA_W-1:0] q_data,
  output logic [CTRL_W-1:0] q_ctrl
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic [CTRL_W-1:0] r_ctrl;

  // Slot register; clear wins over load so a flushed cycle never stores.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_ctrl  <= '0;
    end else if (clear) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
    end else if (load) begin
      r_valid <= 1'b1;
      r_data  <= d_data;
      r_ctrl  <= d_ctrl;
    end
  end

  assign q_valid = r_valid;
  assign q_data  = r_data;
  assign q_ctrl  = r_ctrl;

endmodule

// File: rtl/pipe_stage_hs.sv
// Valid/ready pipeline stage register with flush (bubble insertion).
// Build option: define PIPE_SKID_EN for a 2-entry skid buffer with a
// registered in_ready; otherwise a single entry with combinational in_ready.
module pipe_stage_hs
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = PIPE_DATA_W_DEF,
  parameter int unsigned CTRL_W = PIPE_CTRL_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_data,
  input  logic [CTRL_W-1:0]     in_ctrl,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_data,
  output logic [CTRL_W-1:0]     out_ctrl,
  output logic [PIPE_OCC_W-1:0] occupancy
);

  pipe_state_t       r_state;
  pipe_state_t       w_state_d;
  logic              w_main_load;
  logic              w_main_clear;
  logic [DATA_W-1:0] w_main_d_data;
  logic [CTRL_W-1:0] w_main_d_ctrl;

`ifdef PIPE_SKID_EN
  logic              w_main_sel_skid;
  logic              w_skid_load;
  logic              w_skid_clear;
  logic              w_skid_valid;
  logic [DATA_W-1:0] w_skid_data;
  logic [CTRL_W-1:0] w_skid_ctrl;
`endif

  // Next-state and slot load/clear decode; flush overrides everything.
  always_comb begin
    w_state_d    = r_state;
    w_main_load  = 1'b0;
    w_main_clear = 1'b0;
`ifdef PIPE_SKID_EN
    w_main_sel_skid = 1'b0;
    w_skid_load     = 1'b0;
    w_skid_clear    = 1'b0;
`endif
    if (flush) begin
      w_state_d    = EMPTY;
      w_main_clear = 1'b1;
`ifdef PIPE_SKID_EN
      w_skid_clear = 1'b1;
`endif
    end else begin
      unique case (r_state)
        EMPTY: begin
          if (in_valid) begin
            w_state_d   = BUSY;
            w_main_load = 1'b1;
          end
        end
        BUSY: begin
          if (in_valid && out_ready) begin
            w_main_load = 1'b1;
          end else if (in_valid && !out_ready) begin
`ifdef PIPE_SKID_EN
            // Downstream stalled: park the newer entry behind main.
            w_state_d   = FULL;
            w_skid_load = 1'b1;
`endif
          end else if (!in_valid && out_ready) begin
            w_state_d    = EMPTY;
            w_main_clear = 1'b1;
          end
        end
        FULL: begin
`ifdef PIPE_SKID_EN
          if (out_ready) begin
            w_state_d       = BUSY;
            w_main_load     = 1'b1;
            w_main_sel_skid = 1'b1;
            w_skid_clear    = 1'b1;
          end
`endif
        end
        default: begin
          w_state_d = EMPTY;
        end
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_d;
    end
  end

`ifdef PIPE_SKID_EN
  assign w_main_d_data = w_main_sel_skid ? w_skid_data : in_data;
  assign w_main_d_ctrl = w_main_sel_skid ? w_skid_ctrl : in_ctrl;
  // Depends on the state register only, so no path from out_ready.
  assign in_ready      = (r_state != FULL);
`else
  assign w_main_d_data = in_data;
  assign w_main_d_ctrl = in_ctrl;
  assign in_ready      = !out_valid || out_ready;
`endif

  pipe_entry #(
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W)
  ) u_main (
    .clk     (clk),
    .rst     (rst),
    .load    (w_main_load),
    .clear   (w_main_clear),
    .d_data  (w_main_d_data),
    .d_ctrl  (w_main_d_ctrl),
    .q_valid (out_valid),
    .q_data  (out_data),
    .q_ctrl  (out_ctrl)
  );

`ifdef PIPE_SKID_EN
  pipe_entry #(
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .load    (w_skid_load),
    .clear   (w_skid_clear),
    .d_data  (in_data),
    .d_ctrl  (in_ctrl),
    .q_valid (w_skid_valid),
    .q_data  (w_skid_data),
    .q_ctrl  (w_skid_ctrl)
  );
`endif

  assign occupancy = occ_of_state(r_state);

endmodule
